ahb_master_arbiter: RTL

- Shares the single AHB-Lite master port between NUM_REQ on-core requesters, e.g. instruction fetch (index 0) and load/store (index 1), ahead of BusControl's address decoder.
- Accepts simple valid/ready requests, arbitrates round-robin and sequences one non-pipelined AHB transfer at a time (address phase, then data phase).
- Returns read data and error status to the granted requester.

---
 rtl/ahb_master_arbiter_pkg.sv | 38 +++
 rtl/ahb_master_arbiter_if.sv | 33 +++
 rtl/ahb_master_arbiter_rr_arbiter.sv | 43 ++++
 rtl/ahb_master_arbiter.sv | 119 +++++++++++
 4 files changed

// File: rtl/ahb_master_arbiter_pkg.sv
// Shared AHB-Lite bus types and arbiter state encoding for ahb_master_arbiter.
// Imported by the interface, the round-robin sub-block and the top.
package ahb_master_arbiter_pkg;

  typedef enum logic [2:0] {
    SIZE_BYTE = 3'd0,
    SIZE_HALF = 3'd1,
    SIZE_WORD = 3'd2
  } transfer_size_e;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } transfer_kind_e;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } transfer_response_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

  // Requester index width for 2..4 requesters.
  function automatic int idx_width(input int n);
    return (n > 2) ? 2 : 1;
  endfunction

endpackage

// File: rtl/ahb_master_arbiter_if.sv
// Requester valid/ready bundle plus the AHB-Lite master port; the arbiter
// uses the master modport, requesters and the bus fabric use the slave modport.
interface ahb_master_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_write;
  logic [NUM_REQ-1:0][31:0] req_addr;
  logic [NUM_REQ-1:0][2:0]  req_size;
  logic [NUM_REQ-1:0][31:0] req_wdata;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [31:0]              rsp_rdata;
  logic                     rsp_err;
  logic [31:0]              haddr;
  logic                     hwrite;
  logic [2:0]               hsize;
  logic [1:0]               htrans;
  logic [31:0]              hwdata;
  logic                     hready;
  logic [31:0]              hrdata;
  logic                     hresp;

  modport master (
    input  req_valid, req_write, req_addr, req_size, req_wdata, hready, hrdata, hresp,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, haddr, hwrite, hsize, htrans, hwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_size, req_wdata, hready, hrdata, hresp,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, haddr, hwrite, hsize, htrans, hwdata
  );
endinterface

// File: rtl/ahb_master_arbiter_rr_arbiter.sv
// Round-robin winner select over NUM_REQ requests, searching upward from the pointer.
// The pointer moves to winner+1 only when the grant is taken (adv_i).
module rr_arbiter
  import ahb_master_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IW      = idx_width(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               adv_i,
  output logic               any_o,
  output logic [IW-1:0]      idx_o,
  output logic [NUM_REQ-1:0] gnt_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   sum;

  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    sum   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(i);
      if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
      if (!any_o && req_i[sum[IW-1:0]]) begin
        any_o = 1'b1;
        idx_o = sum[IW-1:0];
      end
    end
  end

  assign gnt_o = any_o ? (NUM_REQ'(1) << idx_o) : '0;
  assign ptr_d = (idx_o == IW'(NUM_REQ - 1)) ? '0 : idx_o + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i)               ptr_q <= '0;
    else if (adv_i && any_o) ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Shares one AHB-Lite master port between NUM_REQ requesters, one non-pipelined transfer
// at a time (IDLE accept, ADDR, DATA, RESP). Define AHB_ARB_TIMEOUT_EN for a DATA wait limit.
module ahb_master_arbiter
  import ahb_master_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                  clock_i,
  input logic                  reset_i,
  ahb_master_arbiter_if.master bus
);

  localparam int IW = idx_width(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_bad_cfg
    $error("ahb_master_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
  end

  arb_state_e         state_q, state_d;
  logic               any, accept;
  logic [IW-1:0]      win_idx, owner_q;
  logic [NUM_REQ-1:0] win_gnt;
  logic [31:0]        addr_q, wdata_q, hwdata_q, rdata_q;
  logic [2:0]         size_q;
  logic               write_q, err_q;
  logic               data_ok, data_err, data_tmo;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk_i (clock_i),
    .rst_i (reset_i),
    .req_i (bus.req_valid),
    .adv_i (accept),
    .any_o (any),
    .idx_o (win_idx),
    .gnt_o (win_gnt)
  );

  assign accept   = (state_q == ST_IDLE) && any && !reset_i;
  assign data_ok  = (state_q == ST_DATA) && bus.hready && (bus.hresp == RESP_OKAY);
  assign data_err = (state_q == ST_DATA) && bus.hready && (bus.hresp == RESP_ERROR);

`ifdef AHB_ARB_TIMEOUT_EN
  logic [7:0] tmo_q;

  // Counter sits at zero outside DATA, so it is clear on every DATA entry.
  always_ff @(posedge clock_i) begin
    if (reset_i || state_q != ST_DATA) tmo_q <= '0;
    else if (!bus.hready)              tmo_q <= tmo_q + 8'd1;
  end

  assign data_tmo = (state_q == ST_DATA) && !bus.hready && (tmo_q == 8'(TIMEOUT_CYCLES - 1));
`else
  assign data_tmo = 1'b0;
`endif

  always_ff @(posedge clock_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_ADDR;
      ST_ADDR: if (bus.hready) state_d = ST_DATA;
      ST_DATA: if (data_ok || data_err || data_tmo) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.htrans    = HTRANS_IDLE;
    unique case (state_q)
      ST_IDLE: if (accept) bus.req_ready = win_gnt;
      ST_ADDR: bus.htrans = HTRANS_NONSEQ;
      ST_RESP: if (!reset_i) bus.rsp_valid = NUM_REQ'(1) << owner_q;
      default: ;
    endcase
  end

  // Request fields are captured at accept; requesters may change them afterwards.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      owner_q  <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
      wdata_q  <= '0;
      hwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        owner_q <= win_idx;
        addr_q  <= bus.req_addr[win_idx];
        write_q <= bus.req_write[win_idx];
        size_q  <= bus.req_size[win_idx];
        wdata_q <= bus.req_wdata[win_idx];
      end
      if (state_q == ST_ADDR && bus.hready) hwdata_q <= wdata_q;
      if (data_ok || data_err || data_tmo) begin
        rdata_q <= data_ok ? bus.hrdata : '0;
        err_q   <= !data_ok;
      end
    end
  end

  assign bus.haddr     = addr_q;
  assign bus.hwrite    = write_q;
  assign bus.hsize     = size_q;
  assign bus.hwdata    = hwdata_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule
